virq_arbiter: RTL and testbench



---
 rtl/virq_arbiter.sv | 137 +++++++++++++
 tb/tb_virq_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/virq_arbiter.sv
// virq_arbiter: vectored interrupt arbiter between peripheral request
// sources and the CPU's single vectored-interrupt input. Picks one eligible
// source, raises cpu_irq, supplies that source's vector during the CPU
// acknowledge handshake and pulses src_ack to the winner for one cycle.
module virq_arbiter #(
  parameter int                 NSRC        = 4,
  parameter logic [NSRC*16-1:0] VECTORS     = {16'o160, 16'o274, 16'o60, 16'o100},
  parameter bit                 ROUND_ROBIN = 1'b0
) (
  input  logic            clk_sys,
  input  logic            reset_n,
  input  logic [NSRC-1:0] src_req,
  input  logic [NSRC-1:0] src_en,
  output logic [NSRC-1:0] src_ack,
  input  logic            cpu_mask,
  output logic            cpu_irq,
  input  logic            cpu_iak,
  output logic            cpu_vack,
  output logic [15:0]     cpu_vector,
  output logic [2:0]      grant_id
);

  localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PEND,
    S_IACK,
    S_REL
  } state_t;

  state_t          state;
  logic [IW-1:0]   grant_idx;   // latched winner
  logic [IW-1:0]   rr_ptr;      // first index considered in rotating mode
  logic            iak_q;       // previous cpu_iak sample for edge detection

  logic [NSRC-1:0] eligible;
  logic            iak_rise;
  logic            winner_keep;
  logic [IW-1:0]   start_idx;
  logic [NSRC-1:0] rotated;
  logic [IW-1:0]   offset;
  logic [IW:0]     win_sum;
  logic [IW-1:0]   win_idx;
  logic [15:0]     win_vector;
  logic [NSRC-1:0] ack_onehot;

  // A masked CPU sees no eligible sources at all.
  assign eligible    = cpu_mask ? '0 : (src_req & src_en);
  assign iak_rise    = cpu_iak & ~iak_q;
  assign winner_keep = src_req[grant_idx] & src_en[grant_idx] & ~cpu_mask;
  assign grant_id    = 3'(grant_idx);

  // Winner search: rotate the eligible set so the start index sits at bit 0,
  // take the lowest set bit, then rotate the offset back.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    start_idx = ROUND_ROBIN ? rr_ptr : '0;
    rotated   = NSRC'({eligible, eligible} >> start_idx);
    offset    = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (rotated[i]) offset = IW'(i);
    end
    win_sum = {1'b0, start_idx} + {1'b0, offset};
    if (win_sum >= (IW+1)'(NSRC)) win_sum = win_sum - (IW+1)'(NSRC);
    win_idx = win_sum[IW-1:0];
  end

  // Vector and ack one-hot for the latched winner.
  always_comb begin
    win_vector = '0;
    ack_onehot = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (grant_idx == IW'(i)) begin
        win_vector    = VECTORS[16*i +: 16];
        ack_onehot[i] = 1'b1;
      end
    end
  end

  // Handshake FSM with registered CPU and source-side outputs.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      grant_idx  <= '0;
      rr_ptr     <= '0;
      iak_q      <= 1'b0;
      cpu_irq    <= 1'b0;
      cpu_vack   <= 1'b0;
      cpu_vector <= '0;
      src_ack    <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      iak_q   <= cpu_iak;
      src_ack <= '0;
      case (state)
        S_IDLE: begin
          if (|eligible) begin
            grant_idx <= win_idx;
            cpu_irq   <= 1'b1;
            state     <= S_PEND;
          end
        end
        S_PEND: begin
          // An acknowledge edge wins over a withdrawal seen in the same cycle.
          if (iak_rise) begin
            cpu_irq    <= 1'b0;
            cpu_vack   <= 1'b1;
            cpu_vector <= win_vector;
            src_ack    <= ack_onehot;
            state      <= S_IACK;
          end else if (!winner_keep) begin
            cpu_irq <= 1'b0;
            state   <= S_IDLE;
          end
        end
        S_IACK: begin
          if (ROUND_ROBIN) begin
            rr_ptr <= (grant_idx == IW'(NSRC - 1)) ? '0 : grant_idx + IW'(1);
          end
          state <= S_REL;
        end
        S_REL: begin
          if (!cpu_iak) begin
            cpu_vack   <= 1'b0;
            cpu_vector <= '0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_virq_arbiter.sv
// Bench for virq_arbiter: a fixed-priority and a rotating-priority instance
// share one input stream; each is compared every cycle against its own
// behavioural model, with directed scenarios followed by random traffic.
module tb_virq_arbiter;

  localparam int          NSRC = 4;
  localparam logic [63:0] VECS = {16'o160, 16'o274, 16'o60, 16'o100};

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [3:0]  src_req, src_en;
  logic        cpu_mask, cpu_iak;
  logic [3:0]  ack_f, ack_r;
  logic        irq_f, irq_r, vack_f, vack_r;
  logic [15:0] vec_f, vec_r;
  logic [2:0]  gid_f, gid_r;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_sys = ~clk_sys;

  virq_arbiter #(.NSRC(NSRC), .VECTORS(VECS), .ROUND_ROBIN(1'b0)) dut_fix (
    .clk_sys(clk_sys), .reset_n(reset_n), .src_req(src_req), .src_en(src_en),
    .src_ack(ack_f), .cpu_mask(cpu_mask), .cpu_irq(irq_f), .cpu_iak(cpu_iak),
    .cpu_vack(vack_f), .cpu_vector(vec_f), .grant_id(gid_f));

  virq_arbiter #(.NSRC(NSRC), .VECTORS(VECS), .ROUND_ROBIN(1'b1)) dut_rr (
    .clk_sys(clk_sys), .reset_n(reset_n), .src_req(src_req), .src_en(src_en),
    .src_ack(ack_r), .cpu_mask(cpu_mask), .cpu_irq(irq_r), .cpu_iak(cpu_iak),
    .cpu_vack(vack_r), .cpu_vector(vec_r), .grant_id(gid_r));

  // Behavioural model: phase 0 waiting, 1 offering irq, 2 vector taken,
  // 3 holding vector until the CPU lets go.
  typedef struct {
    int         phase;
    bit         irq;
    bit         vack;
    logic [15:0] vec;
    logic [3:0] ack;
    int         gid;
    int         next_first;
    bit         iak_prev;
  } model_t;

  model_t m_fix, m_rr;

  function automatic model_t model_reset();
    model_t m;
    m.phase = 0; m.irq = 0; m.vack = 0; m.vec = '0; m.ack = '0;
    m.gid = 0; m.next_first = 0; m.iak_prev = 0;
    return m;
  endfunction

  function automatic int pick(input logic [3:0] elig, input int first);
    for (int k = 0; k < NSRC; k++) begin
      int i;
      i = (first + k) % NSRC;
      if (elig[i]) return i;
    end
    return 0;
  endfunction

  function automatic logic [15:0] vec_of(input int i);
    logic [63:0] v;
    v = VECS;
    return v[16*i +: 16];
  endfunction

  function automatic model_t step(input model_t m, input logic [3:0] req,
                                  input logic [3:0] en, input logic mask,
                                  input logic iak, input bit rr);
    model_t n;
    logic [3:0] elig;
    n = m;
    n.ack = '0;
    n.iak_prev = iak;
    elig = mask ? 4'b0 : (req & en);
    if (m.phase == 0) begin
      if (elig != 0) begin
        n.gid = pick(elig, rr ? m.next_first : 0);
        n.irq = 1; n.phase = 1;
      end
    end else if (m.phase == 1) begin
      if (iak && !m.iak_prev) begin
        n.irq = 0; n.vack = 1; n.vec = vec_of(m.gid);
        n.ack = 4'(1 << m.gid); n.phase = 2;
      end else if (mask || !req[m.gid] || !en[m.gid]) begin
        n.irq = 0; n.phase = 0;
      end
    end else if (m.phase == 2) begin
      if (rr) n.next_first = (m.gid + 1) % NSRC;
      n.phase = 3;
    end else begin
      if (!iak) begin
        n.vack = 0; n.vec = '0; n.phase = 0;
      end
    end
    return n;
  endfunction

  function automatic logic [31:0] pack_m(input model_t m);
    return {7'd0, m.irq, m.vack, m.vec, m.ack, 3'(m.gid)};
  endfunction

  // Model advances on the same edges as the DUTs.
  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      m_fix <= model_reset();
      m_rr  <= model_reset();
    end else begin
      m_fix <= step(m_fix, src_req, src_en, cpu_mask, cpu_iak, 1'b0);
      m_rr  <= step(m_rr,  src_req, src_en, cpu_mask, cpu_iak, 1'b1);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: outputs are compared at the falling edge against both models.
  task automatic cycle();
    @(negedge clk_sys);
    check("fix_model", {7'd0, irq_f, vack_f, vec_f, ack_f, gid_f}, pack_m(m_fix));
    check("rr_model",  {7'd0, irq_r, vack_r, vec_r, ack_r, gid_r}, pack_m(m_rr));
  endtask

  task automatic wait_irq_rr();
    int n;
    n = 0;
    while (!irq_r && n < 10) begin
      cycle();
      n++;
    end
    check("rr_irq_timeout", 32'(irq_r), 32'd1);
  endtask

  initial begin
    int cnt_a, cnt_b;
    logic [15:0] rr_vec [5];
    int          rr_gid [5];
    rr_vec = '{16'o100, 16'o60, 16'o274, 16'o160, 16'o100};
    rr_gid = '{0, 1, 2, 3, 0};

    reset_n = 1'b0; src_req = '0; src_en = 4'hF; cpu_mask = 1'b0; cpu_iak = 1'b0;
    repeat (2) @(negedge clk_sys);
    check("reset_fix", {7'd0, irq_f, vack_f, vec_f, ack_f, gid_f}, 32'd0);
    check("reset_rr",  {7'd0, irq_r, vack_r, vec_r, ack_r, gid_r}, 32'd0);
    reset_n = 1'b1;
    cycle();

    // Fixed priority: src1 and src2 together, src1 wins first.
    src_req = 4'b0110;
    cycle();
    check("fp_irq", 32'(irq_f), 32'd1);
    check("fp_gid", 32'(gid_f), 32'd1);
    cpu_iak = 1'b1;
    cycle();
    check("fp_vec1", 32'(vec_f), 32'(16'o60));
    check("fp_ack1", 32'(ack_f), 32'(4'b0010));
    src_req = 4'b0100; cpu_iak = 1'b0;
    cycle();
    check("fp_ack_once", 32'(ack_f), 32'd0);
    cycle();
    cycle();
    check("fp_irq2", 32'(irq_f), 32'd1);
    cpu_iak = 1'b1;
    cycle();
    check("fp_vec2", 32'(vec_f), 32'(16'o274));
    check("fp_ack2", 32'(ack_f), 32'(4'b0100));
    src_req = '0; cpu_iak = 1'b0;
    cycle();
    cycle();

    // Rotating priority from a fresh pointer, all four requesting.
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    src_req = 4'b1111;
    for (int h = 0; h < 5; h++) begin
      wait_irq_rr();
      check("rr_gid", 32'(gid_r), 32'(rr_gid[h]));
      cpu_iak = 1'b1;
      cycle();
      check("rr_vec", 32'(vec_r), 32'(rr_vec[h]));
      cpu_iak = 1'b0;
      cycle();
      cycle();
    end
    src_req = '0;
    cycle();

    // Withdrawal before acknowledge: no ack, later iak ignored.
    src_req = 4'b0100;
    cycle();
    check("wd_irq", 32'(irq_f), 32'd1);
    src_req = '0;
    cycle();
    check("wd_irq_drop", 32'(irq_f), 32'd0);
    check("wd_no_ack", 32'(ack_f), 32'd0);
    cycle();
    cpu_iak = 1'b1;
    cycle();
    check("wd_vack", 32'(vack_f), 32'd0);
    check("wd_vec", 32'(vec_f), 32'd0);
    cpu_iak = 1'b0;
    cycle();

    // Mask holds off arbitration; irq follows once the mask drops.
    cpu_mask = 1'b1; src_req = 4'b0001;
    cnt_a = 0;
    repeat (20) begin
      cycle();
      cnt_a += int'(irq_f);
    end
    check("mask_irq_cnt", 32'(cnt_a), 32'd0);
    cpu_mask = 1'b0;
    cycle();
    check("mask_release_irq", 32'(irq_f), 32'd1);

    // Long acknowledge: one ack pulse, vector held for the whole iak level.
    cpu_iak = 1'b1;
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (ack_f != 0) cnt_a++;
      cnt_b += int'(vack_f);
      if (i == 0) src_req = '0;
    end
    check("long_ack_cnt", 32'(cnt_a), 32'd1);
    check("long_vack_cnt", 32'(cnt_b), 32'd6);
    cpu_iak = 1'b0;
    cycle();
    check("long_vack_off", 32'(vack_f), 32'd0);

    // Reset during the release phase, iak still high afterwards.
    src_req = 4'b0001;
    cycle();
    cpu_iak = 1'b1;
    cycle();
    cycle();
    check("rel_vack_before", 32'(vack_f), 32'd1);
    reset_n = 1'b0;
    #1;
    check("async_rst_fix", {7'd0, irq_f, vack_f, vec_f, ack_f, gid_f}, 32'd0);
    check("async_rst_rr",  {7'd0, irq_r, vack_r, vec_r, ack_r, gid_r}, 32'd0);
    cycle();
    reset_n = 1'b1;
    cnt_a = 0;
    repeat (4) begin
      cycle();
      cnt_a += int'(vack_f);
    end
    check("post_rst_no_vack", 32'(cnt_a), 32'd0);
    check("post_rst_irq", 32'(irq_f), 32'd1);
    cpu_iak = 1'b0;
    cycle();
    cpu_iak = 1'b1;
    cycle();
    check("post_rst_vack", 32'(vack_f), 32'd1);
    check("post_rst_vec", 32'(vec_f), 32'(16'o100));
    cpu_iak = 1'b0; src_req = '0;
    cycle();
    cycle();

    // Random traffic, including spurious iak and enable/mask changes.
    repeat (3000) begin
      src_req  = 4'($urandom());
      src_en   = ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'hF;
      cpu_mask = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 2) == 0) cpu_iak = ~cpu_iak;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
